// File: rtl/line_word_reader.sv
// Word-read path for a 128-bit cache line: a hit returns a word from the data array, a miss
// returns a word from a line fill guarded by a watchdog. Also keeps saturating hit/miss counters.
module line_word_reader #(
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read_i,
  input  logic [3:0]        req_offset_i,
  output logic              req_ready_o,
  output logic              arr_read_o,
  input  logic              arr_hit_i,
  input  logic [LINE_W-1:0] arr_line_i,
  output logic              fill_req_o,
  input  logic              fill_done_i,
  input  logic [LINE_W-1:0] fill_line_i,
  output logic              rsp_valid_o,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic              rsp_ack_i,
  output logic [CNT_W-1:0]  hit_count_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLookup, StCheck, StFill, StResp} state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   miss_q, miss_d;

  // Word k sits at bits [WORD_W*k +: WORD_W], low byte first.
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [2:0] idx);
    int unsigned base;
    base = int'(idx) * WORD_W;
    return line[base +: WORD_W];
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    err_d   = err_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    unique case (state_q)
      StIdle: begin
        if (req_read_i) begin
          idx_d   = req_offset_i[3:1];
          state_d = StLookup;
        end
      end
      StLookup: state_d = StCheck;
      StCheck: begin
        if (arr_hit_i) begin
          data_d  = word_sel(arr_line_i, idx_q);
          err_d   = 1'b0;
          if (hit_q != '1) hit_d = hit_q + 1'b1;
          state_d = StResp;
        end else begin
          if (miss_q != '1) miss_d = miss_q + 1'b1;
          tmo_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        // A fill landing in the final watchdog cycle still returns data.
        if (fill_done_i) begin
          data_d  = word_sel(fill_line_i, idx_q);
          err_d   = 1'b0;
          state_d = StResp;
        end else if (tmo_q == TmoLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign arr_read_o   = (state_q == StLookup);
  assign fill_req_o   = (state_q == StFill);
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_rdata_o  = data_q;
  assign rsp_err_o    = err_q;
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule
